// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the asynchronous FIFO.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default memory address and word widths
//   ptr_max_t                       : widest pointer the Gray helpers handle
//   bin2gray / gray2bin             : Gray code conversion helpers
//
// The helpers work on a zero-extended ptr_max_t. Leading zeros do not change
// the Gray code of a binary value, and they do not change the binary value of
// a Gray code. A caller of any width up to PTR_MAX_W bits zero-extends its
// operand and truncates the result back to its own width.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PTR_MAX_W      = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf
// Two-entry first-in first-out output buffer. It gives the FIFO its
// first-word-fall-through behaviour.
//   i_clk, i_rst    : clock and synchronous active-high reset
//   i_wr_valid      : capture i_wr_data this cycle
//   i_wr_data       : word returning from memory
//   i_pop           : consumer takes the head word (already qualified by valid)
//   o_dout          : head (oldest) word
//   o_dout_valid    : head word present
//   o_occ           : number of buffered words, 0..2
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  input  logic [Data_Width-1:0] i_wr_data,
  input  logic                  i_pop,
  output logic [Data_Width-1:0] o_dout,
  output logic                  o_dout_valid,
  output logic [1:0]            o_occ
);

  logic [Data_Width-1:0] r_head;
  logic [Data_Width-1:0] r_tail;
  logic [1:0]            r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_wr_valid) begin
            r_head <= i_wr_data;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_wr_valid && i_pop) begin
            r_head <= i_wr_data;
          end else if (i_wr_valid) begin
            r_tail <= i_wr_data;
            r_occ  <= 2'd2;
          end else if (i_pop) begin
            r_occ <= 2'd0;
          end
        end
        2'd2: begin
          // The tail moves up to the head. A word arriving in the same cycle
          // refills the tail slot. A capture without a pop cannot happen here,
          // because the read strobe is throttled by the buffer level.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_wr_valid) begin
              r_tail <= i_wr_data;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign o_dout       = r_head;
  assign o_dout_valid = (r_occ != 2'd0);
  assign o_occ        = r_occ;

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
// Read-side control of the asynchronous FIFO, in the read clock domain.
//   i_rclk, i_rrst    : read clock and synchronous active-high reset
//   i_wptr_s          : Gray write pointer, already synchronized to i_rclk
//   i_rd_data         : memory read data, valid the cycle after o_rd_en
//   o_rd_en           : memory read strobe
//   o_rd_addr         : memory read address
//   o_rptr            : registered Gray read pointer, sent to the write domain
//   o_empty           : no unread word left in memory
//   o_almost_empty    : memory occupancy <= Almost_Empty_Thr
//   o_rd_count        : memory occupancy in words
//   o_dout            : head word of the output buffer
//   o_dout_valid      : o_dout holds a word
//   i_dout_ready      : consumer accepts o_dout
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_Width       = ADDR_WIDTH_DEF,
  parameter int Data_Width       = DATA_WIDTH_DEF,
  parameter int Almost_Empty_Thr = 4
) (
  input  logic                  i_rclk,
  input  logic                  i_rrst,
  input  logic [Addr_Width:0]   i_wptr_s,
  input  logic [Data_Width-1:0] i_rd_data,
  output logic                  o_rd_en,
  output logic [Addr_Width-1:0] o_rd_addr,
  output logic [Addr_Width:0]   o_rptr,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [Addr_Width:0]   o_rd_count,
  output logic [Data_Width-1:0] o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready
);

  localparam int PW = Addr_Width + 1;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rd_count;
  logic          r_empty;
  logic          r_almost_empty;
  logic          r_inflight;

  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rptr_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_mem_level;
  logic [1:0]    w_occ;
  logic [2:0]    w_buf_level;
  logic          w_dout_valid;
  logic          w_pop;
  logic          w_rd_en;

  assign w_pop = w_dout_valid & i_dout_ready;

  // This counts the words the buffer will hold after this cycle if no new read
  // is issued. A read is issued only while that count is below two. The word
  // that comes back next cycle then always has a free slot.
  assign w_buf_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en     = ~r_empty & (w_buf_level < 3'd2);

  assign w_rbin_next = r_rbin + {{Addr_Width{1'b0}}, w_rd_en};
  assign w_rptr_next = PW'(bin2gray(ptr_max_t'(w_rbin_next)));
  assign w_wbin      = PW'(gray2bin(ptr_max_t'(i_wptr_s)));
  assign w_mem_level = w_wbin - w_rbin_next;

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_rbin         <= '0;
      r_rptr         <= '0;
      r_rd_count     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_inflight     <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rptr         <= w_rptr_next;
      r_rd_count     <= w_mem_level;
      r_empty        <= (w_rptr_next == i_wptr_s);
      r_almost_empty <= (w_mem_level <= PW'(Almost_Empty_Thr));
      r_inflight     <= w_rd_en;
    end
  end

  fifo_out_buf #(
    .Data_Width (Data_Width)
  ) u_out_buf (
    .i_clk        (i_rclk),
    .i_rst        (i_rrst),
    .i_wr_valid   (r_inflight),
    .i_wr_data    (i_rd_data),
    .i_pop        (w_pop),
    .o_dout       (o_dout),
    .o_dout_valid (w_dout_valid),
    .o_occ        (w_occ)
  );

  assign o_rd_en        = w_rd_en;
  assign o_rd_addr      = r_rbin[Addr_Width-1:0];
  assign o_rptr         = r_rptr;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_rd_count     = r_rd_count;
  assign o_dout_valid   = w_dout_valid;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int THR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   wptr = '0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] mem [16];

  fifo_read_ctrl #(
    .Addr_Width       (AW),
    .Data_Width       (DW),
    .Almost_Empty_Thr (THR)
  ) dut (
    .i_rclk         (clk),
    .i_rrst         (rst),
    .i_wptr_s       (wptr),
    .i_rd_data      (rd_data),
    .o_rd_en        (rd_en),
    .o_rd_addr      (rd_addr),
    .o_rptr         (rptr),
    .o_empty        (empty),
    .o_almost_empty (almost_empty),
    .o_rd_count     (rd_count),
    .o_dout         (dout),
    .o_dout_valid   (dout_valid),
    .i_dout_ready   (ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic logic [DW-1:0] wdata(input int k);
    return DW'(k * 13 + 5);
  endfunction

  function automatic logic [AW:0] g5(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wptr  = '0;
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int wbin;
    int rdy;
    int e_rd_en;
    int e_addr;
    int e_empty;
    int e_dv;
    int e_dout;
    int e_rptr;
    int e_cnt;
    int e_ae;
  } vec_t;

  vec_t tv [6];

  int pulses, got, wb, popped, reads, seen_msb, cyc;

  initial begin
    // wbin rdy | rd_en addr empty dv dout rptr cnt ae
    tv[0] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[1] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1};
    tv[2] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    tv[3] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    tv[4] = '{1, 1, 0, 1, 1, 1, 5, 1, 0, 1};
    tv[5] = '{1, 1, 0, 1, 1, 0, 5, 1, 0, 1};

    for (int k = 0; k < 16; k++) mem[k] = wdata(k);

    // Reset state and single-word latency
    do_reset();
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_dv", int'(dout_valid), 0);
    chk("rst_rptr", int'(rptr), 0);
    chk("rst_cnt", int'(rd_count), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wptr  = g5(5'(tv[i].wbin));
      ready = (tv[i].rdy != 0);
      #1;
      chk($sformatf("v%0d_rd_en", i), int'(rd_en), tv[i].e_rd_en);
      chk($sformatf("v%0d_addr", i), int'(rd_addr), tv[i].e_addr);
      chk($sformatf("v%0d_empty", i), int'(empty), tv[i].e_empty);
      chk($sformatf("v%0d_dv", i), int'(dout_valid), tv[i].e_dv);
      chk($sformatf("v%0d_dout", i), int'(dout), tv[i].e_dout);
      chk($sformatf("v%0d_rptr", i), int'(rptr), tv[i].e_rptr);
      chk($sformatf("v%0d_cnt", i), int'(rd_count), tv[i].e_cnt);
      chk($sformatf("v%0d_ae", i), int'(almost_empty), tv[i].e_ae);
    end

    // Full memory and a stalled consumer: two reads fill the buffer, then the
    // stall is released and 16 words stream out back to back.
    do_reset();
    for (int k = 0; k < 16; k++) mem[k] = wdata(k);
    wptr   = g5(5'd16);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (rd_en) pulses++;
    end
    chk("fill_pulses", pulses, 2);
    chk("fill_cnt", int'(rd_count), 14);
    chk("fill_dv", int'(dout_valid), 1);
    chk("fill_head", int'(dout), int'(wdata(0)));
    chk("fill_empty", int'(empty), 0);
    chk("fill_ae", int'(almost_empty), 0);
    chk("fill_addr", int'(rd_addr), 2);
    got = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ready = 1'b1;
      #1;
      chk($sformatf("stream_dv%0d", c), int'(dout_valid), 1);
      chk($sformatf("stream_data%0d", c), int'(dout), int'(wdata(c)));
    end
    @(negedge clk);
    #1;
    chk("stream_end_dv", int'(dout_valid), 0);
    chk("stream_end_empty", int'(empty), 1);
    chk("stream_end_rptr", int'(rptr), int'(g5(5'd16)));
    chk("stream_end_cnt", int'(rd_count), 0);

    // Wrap: 40 words through a 16-deep memory with a bursty consumer
    do_reset();
    wb = 0; popped = 0; reads = 0; seen_msb = 0;
    for (cyc = 0; cyc < 2000 && popped < 40; cyc++) begin
      @(negedge clk);
      if (wb < 40 && (wb - popped) < 16) begin
        mem[4'(wb)] = wdata(wb);
        wb++;
        wptr = g5(5'(wb));
      end
      ready = (cyc % 3 != 2);
      #1;
      if (rd_en) begin
        chk("wrap_addr", int'(rd_addr), reads % 16);
        reads++;
      end
      if (rptr[AW]) seen_msb = 1;
      if (dout_valid && ready) begin
        chk("wrap_data", int'(dout), int'(wdata(popped)));
        popped++;
      end
    end
    chk("wrap_popped", popped, 40);
    chk("wrap_reads", reads, 40);
    chk("wrap_msb_seen", seen_msb, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_rptr", int'(rptr), int'(g5(5'd8)));
    chk("wrap_rd_addr", int'(rd_addr), 8);
    chk("wrap_empty", int'(empty), 1);
    chk("wrap_dv", int'(dout_valid), 0);

    // Almost-empty threshold crossing 5 -> 4
    do_reset();
    for (int k = 0; k < 16; k++) mem[k] = wdata(k);
    wptr = g5(5'd5);
    @(negedge clk);
    #1;
    chk("ae_cnt5", int'(rd_count), 5);
    chk("ae_low", int'(almost_empty), 0);
    @(negedge clk);
    #1;
    chk("ae_cnt4", int'(rd_count), 4);
    chk("ae_high", int'(almost_empty), 1);

    // Reset with a word buffered and a read in flight. occ=2 and inflight=1
    // cannot coexist, because the read strobe is throttled by the buffer level.
    do_reset();
    wptr = g5(5'd16);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_dv_before", int'(dout_valid), 1);
    rst  = 1'b1;
    wptr = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_dv", int'(dout_valid), 0);
    chk("mid_rptr", int'(rptr), 0);
    chk("mid_empty", int'(empty), 1);
    chk("mid_cnt", int'(rd_count), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_dv_late", int'(dout_valid), 0);
    chk("mid_rd_en", int'(rd_en), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
